// File: rtl/wbs_spi_host.sv
// wbs_spi_host
// Wishbone classic slave that turns each single-word transfer into one SPI
// frame (mode 0, MSB first) toward an spi_to_wbs-style SPI slave.
//   write frame: 0x02, adr[31:0], dat[31:0]
//   read frame : 0x03, adr[31:0], DUMMY_BITS turnaround bits, 32 data bits in
// Parameters:
//   CLK_DIV    - wb_clk_i cycles per SCK half-period (1..255)
//   DUMMY_BITS - turnaround bits between read address and read data (0..31)
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   wbs_cyc_i, wbs_stb_i    Wishbone request qualifiers
//   wbs_we_i                1 = write frame, 0 = read frame
//   wbs_adr_i, wbs_dat_i    address and write data, both sent in full
//   wbs_dat_o               data from the most recent read frame
//   wbs_ack_o               one-cycle completion pulse
//   busy_o                  high from request accept until back in IDLE
//   spi_sck, spi_cs_n, spi_mosi, spi_miso   SPI master port
module wbs_spi_host #(
  parameter int CLK_DIV    = 2,
  parameter int DUMMY_BITS = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        busy_o,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [7:0] CMD_WR   = 8'h02;
  localparam logic [7:0] CMD_RD   = 8'h03;
  localparam logic [6:0] NBITS_WR = 7'd72;
  localparam logic [6:0] NBITS_RD = 7'(72 + DUMMY_BITS);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    ACK
  } state_t;

  state_t      state;
  logic [7:0]  div_cnt;    // cycles left in the current phase, minus one
  logic [6:0]  bit_cnt;    // bits still to be clocked out
  logic [71:0] shreg;      // outgoing frame, MSB is the bit on mosi
  logic [31:0] rd_shift;   // every sampled miso bit; the last 32 are kept
  logic [31:0] rd_data;
  logic        we_lat;
  logic        aborted;    // cyc dropped at some point during this frame
  logic        sck;
  logic        cs_n;
  logic        mosi;
  logic        ack;
  logic        busy;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      div_cnt  <= 8'd0;
      bit_cnt  <= 7'd0;
      shreg    <= 72'd0;
      rd_shift <= 32'd0;
      rd_data  <= 32'd0;
      we_lat   <= 1'b0;
      aborted  <= 1'b0;
      sck      <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
      ack      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          if (wbs_cyc_i && wbs_stb_i && !ack) begin
            state   <= CS_SETUP;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            we_lat  <= wbs_we_i;
            aborted <= 1'b0;
            div_cnt <= DIV_LAST;
            // Read frames carry zeros in the data slot so that mosi is
            // naturally 0 for the turnaround and data bits.
            shreg   <= {(wbs_we_i ? CMD_WR : CMD_RD), wbs_adr_i,
                        (wbs_we_i ? wbs_dat_i : 32'd0)};
            mosi    <= wbs_we_i ? CMD_WR[7] : CMD_RD[7];
            bit_cnt <= wbs_we_i ? NBITS_WR : NBITS_RD;
          end
        end

        CS_SETUP: begin
          if (div_cnt == 8'd0) begin
            state   <= SHIFT;
            div_cnt <= DIV_LAST;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end

        SHIFT: begin
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            div_cnt <= DIV_LAST;
            if (!sck) begin
              sck <= 1'b1;
            end else begin
              // End of a high phase: sample miso on the same edge that
              // drops sck, and present the next bit.
              sck      <= 1'b0;
              rd_shift <= {rd_shift[30:0], spi_miso};
              bit_cnt  <= bit_cnt - 7'd1;
              if (bit_cnt == 7'd1) begin
                state <= CS_HOLD;
                mosi  <= 1'b0;
              end else begin
                shreg <= {shreg[70:0], 1'b0};
                mosi  <= shreg[70];
              end
            end
          end
        end

        CS_HOLD: begin
          if (div_cnt == 8'd0) begin
            state <= ACK;
            cs_n  <= 1'b1;
            ack   <= wbs_cyc_i && !aborted;
            if (!we_lat) begin
              rd_data <= rd_shift;
            end
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end

        ACK: begin
          state <= IDLE;
          ack   <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          cs_n  <= 1'b1;
          sck   <= 1'b0;
          ack   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase

      // A dropped cycle never truncates the frame; it only suppresses ack.
      if (busy && !wbs_cyc_i) begin
        aborted <= 1'b1;
      end
    end
  end

  assign wbs_dat_o = rd_data;
  assign wbs_ack_o = ack;
  assign busy_o    = busy;
  assign spi_sck   = sck;
  assign spi_cs_n  = cs_n;
  assign spi_mosi  = mosi;

endmodule

// File: doc/wbs_spi_host.md
# wbs_spi_host

Wishbone-slave to SPI-master bridge: each Wishbone classic single-word transfer becomes one SPI frame toward an `spi_to_wbs`-style SPI slave, the SPI port of the FPGA core wrapper. Used by the test harness and by on-chip configuration controllers to write eFPGA bitstream words and read status over the wrapper's 4-wire SPI.
- SPI mode 0, MSB first.
- Write frame: cmd 0x02, adr[31:0], dat[31:0].
- Read frame: cmd 0x03, adr[31:0], DUMMY_BITS idle bits, then 32 data bits on MISO.

## Interface
- CLK_DIV, 2: `wb_clk_i` cycles per SCK half-period; legal values 1..255.
- DUMMY_BITS, 8: turnaround bits between read address and read data; legal values 0..31.

- wb_clk_i  in  1  sole clock; all logic rises on it.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  1 = write frame, 0 = read frame.
- wbs_adr_i  in  32  address; all 32 bits are sent.
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  last read data.
- wbs_ack_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high from request accept until return to IDLE.
- spi_sck  out  1  SPI clock; idles low.
- spi_cs_n  out  1  chip select, active low.
- spi_mosi  out  1  master out.
- spi_miso  in  1  master in.

## Operation
- States: IDLE → CS_SETUP → SHIFT → CS_HOLD → ACK → IDLE.
- IDLE:
  - Accept a request when cyc&stb are high and ack is low.
  - Latch we, adr and dat into a 72-bit shift register {cmd, adr, dat}.
  - Load the bit counter with NBITS: 72 for writes; 72+DUMMY_BITS for reads.
- CS_SETUP:
  - cs_n is low and sck is low for CLK_DIV cycles.
  - mosi is driven to the frame's first bit (cmd[7]).
- SHIFT: each bit is CLK_DIV cycles sck-low followed by CLK_DIV cycles sck-high.
  - mosi changes only on the cycle sck goes low.
  - On a read, once cmd+adr (40 bits) have been sent, mosi is driven 0 for the remaining bits.
  - spi_miso is sampled on the wb_clk edge that ends each high phase, i.e. the edge that drives sck 1→0.
  - On a read, the last 32 sampled bits shift into a read register, MSB first.
  - SHIFT ends when the counter reaches 0 after the final high phase.
- CS_HOLD: sck is low and cs_n stays low for CLK_DIV cycles.
- ACK:
  - cs_n goes high.
  - wbs_ack_o is pulsed for 1 cycle, but only if cyc_i is still high.
  - On a read, wbs_dat_o is updated on the same edge.
- Writes never modify wbs_dat_o.
- Abort: if cyc_i drops mid-frame, the SPI frame still completes (no truncated frames) and ack is suppressed.
- Reset values: sck=0, cs_n=1, mosi=0, ack=0, busy=0, dat_o=0, state=IDLE.
- Reset asserted mid-frame: on the next edge, cs_n=1, sck=0, all outputs take their reset values, and no ack is issued.

## Timing
- T is the IDLE cycle in which the request is sampled.
- cs_n falls at T+1.
- First sck rising edge at T+2·CLK_DIV+1.
- Final sck falling edge at T+(2·NBITS+1)·CLK_DIV+1.
- ack is high during cycle T+(2·NBITS+2)·CLK_DIV+1, with cs_n high in that same cycle.
  - CLK_DIV=2 write: ack at T+293.
  - CLK_DIV=2, DUMMY_BITS=8 read: ack at T+325.
- Back-to-back requests:
  - IDLE lasts at least 1 cycle after ACK, so cs_n is high for ≥2 cycles between frames.
  - A strobe held through ack starts the next frame at ack+1.
- busy_o rises at T+1 and falls on the ACK→IDLE edge.
- Every sck half-period is exactly CLK_DIV cycles; sck has no glitches and only toggles while cs_n is low.

## Test plan
- Reset, then idle 20 cycles -> sck=0, cs_n=1, mosi=0, ack=0, busy=0, dat_o=0 throughout.
- Write adr=0x0000_1004, dat=0xDEADBEEF, CLK_DIV=2 -> SPI slave model captures 72 bits 0x02,0x00001004,0xDEADBEEF; exactly 72 sck rising edges; ack at T+293; dat_o unchanged.
- Read adr=0x0000_2000; slave returns 0xA5A5_0F0F after 8 dummy bits -> 80 sck edges; mosi=0 after bit 40; ack at T+325 with dat_o=0xA5A50F0F.
- Back-to-back write then read with stb held high -> second cs_n fall exactly 2 cycles after first cs_n rise; both acks single-cycle.
- wb_rst_i pulsed at bit 30 of a write -> cs_n=1, sck=0 the next cycle; no ack; a following write completes normally.
- CLK_DIV=1, DUMMY_BITS=0 read -> sck period of 2 cycles; ack at T+(2·72+2)+1 = T+147; data correct.
